dense_argmax: RTL
=================

Name: dense_argmax

Overview:
- Classifier stage directly downstream of the dense layer.
- Waits for the dense layer's output vector to become ready (rising edge of its `resting` flag) and snapshots the vector.
- Scans the N signed Q1.15 scores sequentially, one per cycle.
- Reports the winning class index, the runner-up index and the decision margin, with a done pulse and a held valid flag.

Parameters:
- N, 100, number of dense outputs (equals the dense layer's n).
- W, 16, element width, signed Q1.15.
- IDX_W, 7, index width, $clog2(N); must satisfy 2^IDX_W >= N.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low (rst=0 resets).
- y_in  in  W*N  dense output vector; element i at [W*(i+1)-1 -: W].
- start  in  1  connected to dense `resting`; only the rising edge triggers.
- busy  out  1  high while capturing or scanning.
- done  out  1  one-cycle pulse when results update.
- valid  out  1  high from first done until reset.
- class_idx  out  IDX_W  index of the maximum score.
- class_val  out  W  maximum score, signed.
- second_idx  out  IDX_W  index of the second-highest score.
- margin  out  W  unsigned class_val − second score (0..65535).
- overrun  out  1  sticky; a start edge arrived while busy.

Behaviour:
- Reset values: all outputs 0. State IDLE, counter 0.
- The start edge-detect register resets to 1, so start held high across reset release does not trigger.
- Edge detect: `trig = start & ~start_d`. start_d is registered every cycle.
- IDLE:
  - On trig, latch y_in into the snapshot register at the same edge.
  - Initialise best = snap[0], best_idx = 0, sec = −32768, sec_idx = 0, i = 1.
  - Go to SCAN (N>1) or FIN (N=1).
- SCAN, one element per cycle (e = snap[i], signed compare):
  - If e > best: sec ← best, sec_idx ← best_idx, best ← e, best_idx ← i.
  - Else if e > sec, or (sec_idx == best_idx and i > 0 and sec is still the initial value): sec ← e, sec_idx ← i.
  - Strict ">" throughout, so ties keep the lower index. For equal values the runner-up is the lowest index other than best_idx.
  - When i == N−1, the update is applied and the state moves to FIN. Otherwise i ← i+1.
- FIN, one cycle:
  - Register class_idx, class_val, second_idx.
  - margin = best − sec, computed in W+1 bits and truncated to W bits as unsigned; the result is never negative.
  - Assert done for exactly this cycle, set valid, return to IDLE.
- Latency: done is high in the cycle beginning N clocks after the capturing edge. For N=100 that is 100 clocks; for N=1, 1 clock.
- busy is high in SCAN and FIN. It goes high the cycle after the trig edge and low when done drops.
- Result outputs hold their values between runs. They change only in FIN.
- Snapshot isolation: changes on y_in after the capture edge do not affect the result.
- trig while busy is ignored and sets overrun (sticky until reset).
- trig in the same cycle as FIN is ignored (overrun set). A trig in the first IDLE cycle after FIN is accepted.
- Reset mid-scan: immediate return to IDLE and all outputs 0. No done is produced for the aborted run.
- N=1: second_idx = 0, margin = snap[0] + 32768.

Decomposition:
- Shared package cnn_pkg:
  - Q_W = 16.
  - Q15_MAX = 16'sh7FFF, Q15_MIN = 16'sh8000.
  - Enum argmax_state_t {IDLE, SCAN, FIN}.
- One natural sub-module, argmax_top2_upd: combinational next-state for (best, best_idx, sec, sec_idx) given element e and index i. It is reusable by a later top-k or softmax stage.
- The FSM, counter, snapshot register and output registers stay in dense_argmax.

Test Plan:
- All 100 elements = 32767, start 0→1 → done exactly 100 clocks after the capture edge; class_idx=0, class_val=32767, second_idx=1, margin=0.
- Element 57 = 1000, all others = −5 → class_idx=57, class_val=1000, second_idx=0, margin=1005; valid=1 afterwards.
- Element 3 = 32767, all others = −32768 → class_idx=3, second_idx=0, margin=65535 (no wrap to 0).
- All = −32768 except element 99 = −1 and element 40 = −2 → class_idx=99, second_idx=40, margin=1. During the run, y_in is zeroed 5 cycles after capture → result unchanged.
- Second start edge 20 cycles into a scan → ignored, overrun=1, single done; results match the first vector.
- rst=0 asserted at scan cycle 50 with start held high, then released → all outputs 0, no done. A fresh 0→1 start then completes normally with correct results.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and Q1.15 constants for the CNN classifier stages.
package cnn_pkg;

    localparam int Q_W = 16;
    localparam logic signed [Q_W-1:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [Q_W-1:0] Q15_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FIN
    } argmax_state_t;

endpackage

// File: rtl/argmax_top2_upd.sv
// Combinational top-2 tracker update: folds element e_i at index idx_i into
// the running (best, runner-up) pair. Strict compares keep the lower index on ties.
module argmax_top2_upd #(
    parameter int W     = 16,
    parameter int IDX_W = 7
) (
    input  logic signed [W-1:0]     e_i,
    input  logic        [IDX_W-1:0] idx_i,
    input  logic signed [W-1:0]     best_i,
    input  logic        [IDX_W-1:0] best_idx_i,
    input  logic signed [W-1:0]     sec_i,
    input  logic        [IDX_W-1:0] sec_idx_i,
    output logic signed [W-1:0]     best_o,
    output logic        [IDX_W-1:0] best_idx_o,
    output logic signed [W-1:0]     sec_o,
    output logic        [IDX_W-1:0] sec_idx_o
);

    localparam logic signed [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

    logic sec_unset;

    // The runner-up still aliases best's slot at its initial minimum: the first
    // non-best element must claim it even if equal, so all-equal vectors get idx 1.
    assign sec_unset = (sec_idx_i == best_idx_i) && (idx_i != '0) && (sec_i == MIN_S);

    always_comb begin
        best_o     = best_i;
        best_idx_o = best_idx_i;
        sec_o      = sec_i;
        sec_idx_o  = sec_idx_i;
        if (e_i > best_i) begin
            sec_o      = best_i;
            sec_idx_o  = best_idx_i;
            best_o     = e_i;
            best_idx_o = idx_i;
        end else if ((e_i > sec_i) || sec_unset) begin
            sec_o     = e_i;
            sec_idx_o = idx_i;
        end
    end

endmodule

// File: rtl/dense_argmax.sv
// Argmax classifier behind the dense layer: snapshots the score vector on the
// rising edge of start, scans one score per cycle, reports top-1/top-2 and margin.
module dense_argmax
    import cnn_pkg::*;
#(
    parameter int N     = 100,
    parameter int W     = Q_W,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W*N-1:0]          y_in,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [IDX_W-1:0]        class_idx,
    output logic signed [W-1:0]     class_val,
    output logic [IDX_W-1:0]        second_idx,
    output logic [W-1:0]            margin,
    output logic                    overrun
);

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [W-1:0] MIN_S    = {1'b1, {(W-1){1'b0}}};

    argmax_state_t state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic signed [W-1:0] best_q, best_d, sec_q, sec_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d, sec_idx_q, sec_idx_d;
    logic signed [W-1:0] upd_best, upd_sec;
    logic [IDX_W-1:0]    upd_best_idx, upd_sec_idx;
    logic signed [W-1:0] snap_q [N];
    logic start_q, trig, capture;
    logic done_q, valid_q, overrun_q;
    logic [IDX_W-1:0]    class_idx_q, second_idx_q;
    logic signed [W-1:0] class_val_q;
    logic [W-1:0]        margin_q;

    assign trig    = start & ~start_q;
    assign capture = trig && (state_q == IDLE);

    argmax_top2_upd #(.W(W), .IDX_W(IDX_W)) u_upd (
        .e_i        (snap_q[cnt_q]),
        .idx_i      (cnt_q),
        .best_i     (best_q),
        .best_idx_i (best_idx_q),
        .sec_i      (sec_q),
        .sec_idx_i  (sec_idx_q),
        .best_o     (upd_best),
        .best_idx_o (upd_best_idx),
        .sec_o      (upd_sec),
        .sec_idx_o  (upd_sec_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        sec_d      = sec_q;
        sec_idx_d  = sec_idx_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    best_d     = y_in[W-1:0];
                    best_idx_d = '0;
                    sec_d      = MIN_S;
                    sec_idx_d  = '0;
                    cnt_d      = IDX_W'(1);
                    state_d    = (N > 1) ? SCAN : FIN;
                end
            end
            SCAN: begin
                best_d     = upd_best;
                best_idx_d = upd_best_idx;
                sec_d      = upd_sec;
                sec_idx_d  = upd_sec_idx;
                if (cnt_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot isolates the scan from y_in changes after the capture edge.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= y_in[W*k +: W];
            end
        end
    end

    // start_q resets high so a start held across reset release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            sec_q        <= '0;
            sec_idx_q    <= '0;
            start_q      <= 1'b1;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            class_idx_q  <= '0;
            class_val_q  <= '0;
            second_idx_q <= '0;
            margin_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            sec_q      <= sec_d;
            sec_idx_q  <= sec_idx_d;
            start_q    <= start;
            done_q     <= (state_q == FIN);
            if (trig && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (state_q == FIN) begin
                class_idx_q  <= best_idx_q;
                class_val_q  <= best_q;
                second_idx_q <= sec_idx_q;
                // best >= sec always, so the W-bit difference is exact (0..2^W-1).
                margin_q     <= best_q - sec_q;
                valid_q      <= 1'b1;
            end
        end
    end

    assign busy       = (state_q != IDLE) || done_q;
    assign done       = done_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign class_idx  = class_idx_q;
    assign class_val  = class_val_q;
    assign second_idx = second_idx_q;
    assign margin     = margin_q;

endmodule
